// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
// Shares one single-port valid/ready memory between requesters A and B with
// round-robin arbitration and a ready-timeout watchdog.
//
// Handshake: a requester raises <x>_req_i with its qualifiers and holds them
// until <x>_ack_o, which is a one-cycle pulse; <x>_err_o is meaningful only
// while ack is high. Toward the memory, m_valid_o is a one-cycle pulse that
// carries m_wr_rd_en_o/m_addr_o/m_wdata_o. The access completes when m_ready_i
// is seen during WAIT, with m_rdata_i valid in that same cycle for reads.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   a_* / b_*               requester ports (req, wr_rd_en, addr, wdata in;
//                           ack, err, rdata out)
//   m_*                     memory master port
//   busy_o                  high whenever the FSM is not in IDLE
//   grant_o                 current or last owner (0 = A, 1 = B)
//   state_o                 FSM state, for observation
module mem_rr_arbiter #(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_req_i,
    input  logic                  a_wr_rd_en_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [WIDTH-1:0]      a_wdata_i,
    output logic                  a_ack_o,
    output logic                  a_err_o,
    output logic [WIDTH-1:0]      a_rdata_o,
    input  logic                  b_req_i,
    input  logic                  b_wr_rd_en_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [WIDTH-1:0]      b_wdata_i,
    output logic                  b_ack_o,
    output logic                  b_err_o,
    output logic [WIDTH-1:0]      b_rdata_o,
    output logic                  m_valid_o,
    output logic                  m_wr_rd_en_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [WIDTH-1:0]      m_wdata_o,
    input  logic [WIDTH-1:0]      m_rdata_i,
    input  logic                  m_ready_i,
    output logic                  busy_o,
    output logic                  grant_o,
    output logic [1:0]            state_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_wr_q, m_wr_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [WIDTH-1:0]      m_wdata_q, m_wdata_d;
    logic                  a_ack_q, a_ack_d, a_err_q, a_err_d;
    logic                  b_ack_q, b_ack_d, b_err_q, b_err_d;
    logic [WIDTH-1:0]      a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                  pick_b;
    logic                  finish;
    logic                  timed_out;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        m_valid_d    = 1'b0;
        m_wr_d       = m_wr_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        a_ack_d      = 1'b0;
        a_err_d      = 1'b0;
        b_ack_d      = 1'b0;
        b_err_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        pick_b       = 1'b0;
        finish       = 1'b0;
        timed_out    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (a_req_i || b_req_i) begin
                    // B wins when it is alone, or when both ask and A was served last.
                    pick_b       = b_req_i && (!a_req_i || !last_grant_q);
                    grant_d      = pick_b;
                    last_grant_d = pick_b;
                    m_wr_d       = pick_b ? b_wr_rd_en_i : a_wr_rd_en_i;
                    m_addr_d     = pick_b ? b_addr_i     : a_addr_i;
                    m_wdata_d    = pick_b ? b_wdata_i    : a_wdata_i;
                    m_valid_d    = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_ready_i) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        finish    = 1'b1;
                        timed_out = 1'b1;
                    end
                end
                if (finish) begin
                    state_d = S_DONE;
                    if (grant_q) begin
                        b_ack_d = 1'b1;
                        b_err_d = timed_out;
                    end else begin
                        a_ack_d = 1'b1;
                        a_err_d = timed_out;
                    end
                    // Only a successful read updates the owner's data.
                    if (!timed_out && !m_wr_q) begin
                        if (grant_q) b_rdata_d = m_rdata_i;
                        else         a_rdata_d = m_rdata_i;
                    end
                end
            end
            S_DONE: begin
                // Requests are not sampled here: the owner is still dropping req.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            m_valid_q    <= 1'b0;
            m_wr_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            a_ack_q      <= 1'b0;
            a_err_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            b_err_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            m_valid_q    <= m_valid_d;
            m_wr_q       <= m_wr_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            a_ack_q      <= a_ack_d;
            a_err_q      <= a_err_d;
            b_ack_q      <= b_ack_d;
            b_err_q      <= b_err_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign a_ack_o      = a_ack_q;
    assign a_err_o      = a_err_q;
    assign a_rdata_o    = a_rdata_q;
    assign b_ack_o      = b_ack_q;
    assign b_err_o      = b_err_q;
    assign b_rdata_o    = b_rdata_q;
    assign m_valid_o    = m_valid_q;
    assign m_wr_rd_en_o = m_wr_q;
    assign m_addr_o     = m_addr_q;
    assign m_wdata_o    = m_wdata_q;
    assign busy_o       = busy_q;
    assign grant_o      = grant_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: a responsive memory model, directed steps from the
// test plan, then randomized traffic checked against a transaction-level model.
module tb_mem_rr_arbiter;

    localparam int W  = 16;
    localparam int AW = 6;
    localparam int TO = 15;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic          a_req_i, a_wr_rd_en_i, b_req_i, b_wr_rd_en_i;
    logic [AW-1:0] a_addr_i, b_addr_i;
    logic [W-1:0]  a_wdata_i, b_wdata_i;
    logic          a_ack_o, a_err_o, b_ack_o, b_err_o;
    logic [W-1:0]  a_rdata_o, b_rdata_o;
    logic          m_valid_o, m_wr_rd_en_o, m_ready_i;
    logic [AW-1:0] m_addr_o;
    logic [W-1:0]  m_wdata_o, m_rdata_i;
    logic          busy_o, grant_o;
    logic [1:0]    state_o;

    mem_rr_arbiter #(.DEPTH(64), .WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_req_i(a_req_i), .a_wr_rd_en_i(a_wr_rd_en_i), .a_addr_i(a_addr_i),
        .a_wdata_i(a_wdata_i), .a_ack_o(a_ack_o), .a_err_o(a_err_o), .a_rdata_o(a_rdata_o),
        .b_req_i(b_req_i), .b_wr_rd_en_i(b_wr_rd_en_i), .b_addr_i(b_addr_i),
        .b_wdata_i(b_wdata_i), .b_ack_o(b_ack_o), .b_err_o(b_err_o), .b_rdata_o(b_rdata_o),
        .m_valid_o(m_valid_o), .m_wr_rd_en_o(m_wr_rd_en_o), .m_addr_o(m_addr_o),
        .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i), .m_ready_i(m_ready_i),
        .busy_o(busy_o), .grant_o(grant_o), .state_o(state_o)
    );

    // ---------------- memory model ----------------
    // Sees m_valid, then returns a one-cycle ready (with read data) in the
    // following cycle. mem_alive = 0 models a dead memory.
    logic [W-1:0]  slave_mem [64];
    bit            mem_alive = 1'b1;
    bit            pend = 1'b0;
    logic [AW-1:0] pend_addr;

    always @(negedge clk_i) begin
        m_ready_i = 1'b0;
        if (pend) begin
            if (mem_alive) begin
                m_ready_i = 1'b1;
                m_rdata_i = slave_mem[pend_addr];
            end
            pend = 1'b0;
        end
        if (m_valid_o === 1'b1) begin
            pend      = 1'b1;
            pend_addr = m_addr_o;
            if (m_wr_rd_en_o) slave_mem[m_addr_o] = m_wdata_o;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0] ref_mem [64];
    bit           last_grant;
    logic [W-1:0] rd_model [2];
    logic [W-1:0] exp_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    function automatic bit pick(input bit ra, input bit rb);
        if (ra && rb) return !last_grant;
        return rb;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input bit who, input bit on, input bit wr,
                           input logic [AW-1:0] addr, input logic [W-1:0] data);
        if (who) begin
            b_req_i = on; b_wr_rd_en_i = wr; b_addr_i = addr; b_wdata_i = data;
        end else begin
            a_req_i = on; a_wr_rd_en_i = wr; a_addr_i = addr; a_wdata_i = data;
        end
    endtask

    // Follows one access of 'owner' from the current negedge to its ack,
    // checking the memory pulse, latency, err and data, then drops its req.
    task automatic serve(input bit owner, input bit wr, input logic [AW-1:0] addr,
                         input logic [W-1:0] wdata, input bit exp_err, input int exp_lat);
        int n = 0;
        int vcnt = 0;
        bit got = 1'b0;
        logic [W-1:0] exp_rd;
        last_grant = owner;
        if (!exp_err) begin
            if (wr) ref_mem[addr] = wdata;
            else    rd_model[owner] = ref_mem[addr];
        end
        exp_q.push_back(rd_model[owner]);
        while (!got && n < 60) begin
            @(negedge clk_i);
            n++;
            if (m_valid_o === 1'b1) begin
                vcnt++;
                check("m_addr", 32'(m_addr_o), 32'(addr));
                check("m_wdata", 32'(m_wdata_o), 32'(wdata));
                check("m_wr_rd_en", 32'(m_wr_rd_en_o), 32'(wr));
                check("grant", 32'(grant_o), 32'(owner));
                check("busy_active", 32'(busy_o), 32'd1);
            end
            check("nonowner_ack", 32'(owner ? a_ack_o : b_ack_o), 32'd0);
            if ((owner ? b_ack_o : a_ack_o) === 1'b1) got = 1'b1;
        end
        exp_rd = exp_q.pop_front();
        check("ack_seen", 32'(got), 32'd1);
        check("ack_latency", 32'(n), 32'(exp_lat));
        check("valid_pulses", 32'(vcnt), 32'd1);
        check("err", 32'(owner ? b_err_o : a_err_o), 32'(exp_err));
        check("owner_rdata", 32'(owner ? b_rdata_o : a_rdata_o), 32'(exp_rd));
        check("other_rdata", 32'(owner ? a_rdata_o : b_rdata_o), 32'(rd_model[!owner]));
        set_req(owner, 1'b0, 1'b0, '0, '0);
    endtask

    // One cycle after an ack: back in IDLE with both acks low.
    task automatic idle_gap();
        @(negedge clk_i);
        check("gap_a_ack", 32'(a_ack_o), 32'd0);
        check("gap_b_ack", 32'(b_ack_o), 32'd0);
        check("gap_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_m_valid", 32'(m_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_a_ack", 32'(a_ack_o), 32'd0);
        check("rst_b_ack", 32'(b_ack_o), 32'd0);
        check("rst_a_err", 32'(a_err_o), 32'd0);
        check("rst_b_err", 32'(b_err_o), 32'd0);
        check("rst_a_rdata", 32'(a_rdata_o), 32'd0);
        check("rst_b_rdata", 32'(b_rdata_o), 32'd0);
        check("rst_m_addr", 32'(m_addr_o), 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit            first;
        bit            pa_wr, pb_wr;
        logic [AW-1:0] pa_addr, pb_addr;
        logic [W-1:0]  pa_data, pb_data;
        int            pat;

        for (int i = 0; i < 64; i++) begin
            slave_mem[i] = '0;
            ref_mem[i]   = '0;
        end
        rd_model[0] = '0;
        rd_model[1] = '0;
        last_grant  = 1'b1;
        m_ready_i   = 1'b0;
        m_rdata_i   = '0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        rst_i = 1'b0;
        #2 rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_reset_outputs();
        rst_i = 1'b0;
        @(negedge clk_i);

        // A writes 0xBEEF to 5, then reads it back.
        set_req(1'b0, 1'b1, 1'b1, 6'd5, 16'hBEEF);
        serve(1'b0, 1'b1, 6'd5, 16'hBEEF, 1'b0, 3);
        idle_gap();
        set_req(1'b0, 1'b1, 1'b0, 6'd5, 16'h0000);
        serve(1'b0, 1'b0, 6'd5, 16'h0000, 1'b0, 3);
        check("a_read_beef", 32'(a_rdata_o), 32'h0000BEEF);
        check("b_ack_quiet", 32'(b_ack_o), 32'd0);
        check("b_err_quiet", 32'(b_err_o), 32'd0);
        check("b_rdata_quiet", 32'(b_rdata_o), 32'd0);
        idle_gap();

        // B alone, so A is next in line for the contention below.
        set_req(1'b1, 1'b1, 1'b0, 6'd2, 16'h0000);
        serve(1'b1, 1'b0, 6'd2, 16'h0000, 1'b0, 3);
        idle_gap();

        // Contention: A, B, A, B with acks 4 cycles apart.
        set_req(1'b0, 1'b1, 1'b1, 6'd1, 16'h1111);
        set_req(1'b1, 1'b1, 1'b1, 6'd2, 16'h2222);
        first = pick(1'b1, 1'b1);
        check("contend_first_a", 32'(first), 32'd0);
        serve(1'b0, 1'b1, 6'd1, 16'h1111, 1'b0, 3);
        set_req(1'b0, 1'b1, 1'b0, 6'd1, 16'h0000);
        serve(1'b1, 1'b1, 6'd2, 16'h2222, 1'b0, 4);
        set_req(1'b1, 1'b1, 1'b0, 6'd2, 16'h0000);
        serve(1'b0, 1'b0, 6'd1, 16'h0000, 1'b0, 4);
        check("readback_1111", 32'(a_rdata_o), 32'h00001111);
        serve(1'b1, 1'b0, 6'd2, 16'h0000, 1'b0, 4);
        check("readback_2222", 32'(b_rdata_o), 32'h00002222);
        idle_gap();

        // Dead memory: B read times out after TO WAIT cycles, data kept.
        mem_alive = 1'b0;
        set_req(1'b1, 1'b1, 1'b0, 6'd7, 16'h0000);
        serve(1'b1, 1'b0, 6'd7, 16'h0000, 1'b1, TO + 2);
        check("timeout_rdata_kept", 32'(b_rdata_o), 32'h00002222);
        mem_alive = 1'b1;
        idle_gap();
        set_req(1'b0, 1'b1, 1'b0, 6'd1, 16'h0000);
        serve(1'b0, 1'b0, 6'd1, 16'h0000, 1'b0, 3);
        idle_gap();

        // Reset while an A read is in WAIT.
        set_req(1'b0, 1'b1, 1'b0, 6'd5, 16'h0000);
        @(negedge clk_i);
        check("pre_rst_valid", 32'(m_valid_o), 32'd1);
        @(negedge clk_i);
        check("pre_rst_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check_reset_outputs();
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) begin
            @(negedge clk_i);
            check("rst_no_ack", 32'(a_ack_o), 32'd0);
        end
        rst_i       = 1'b0;
        last_grant  = 1'b1;
        rd_model[0] = '0;
        rd_model[1] = '0;
        @(negedge clk_i);

        // After reset A wins; top address and full data width.
        set_req(1'b0, 1'b1, 1'b1, 6'd63, 16'hFFFF);
        set_req(1'b1, 1'b1, 1'b0, 6'd2, 16'h0000);
        serve(1'b0, 1'b1, 6'd63, 16'hFFFF, 1'b0, 3);
        serve(1'b1, 1'b0, 6'd2, 16'h0000, 1'b0, 4);
        idle_gap();
        set_req(1'b0, 1'b1, 1'b0, 6'd63, 16'h0000);
        serve(1'b0, 1'b0, 6'd63, 16'h0000, 1'b0, 3);
        check("top_addr_ffff", 32'(a_rdata_o), 32'h0000FFFF);
        idle_gap();

        // Random traffic: A alone, B alone, or both together.
        for (int i = 0; i < 40; i++) begin
            pat     = $urandom_range(0, 2);
            pa_wr   = 1'($urandom_range(0, 1));
            pb_wr   = 1'($urandom_range(0, 1));
            pa_addr = AW'($urandom_range(0, 63));
            pb_addr = AW'($urandom_range(0, 63));
            pa_data = W'($urandom);
            pb_data = W'($urandom);
            if (pat == 0) begin
                set_req(1'b0, 1'b1, pa_wr, pa_addr, pa_data);
                serve(1'b0, pa_wr, pa_addr, pa_data, 1'b0, 3);
            end else if (pat == 1) begin
                set_req(1'b1, 1'b1, pb_wr, pb_addr, pb_data);
                serve(1'b1, pb_wr, pb_addr, pb_data, 1'b0, 3);
            end else begin
                set_req(1'b0, 1'b1, pa_wr, pa_addr, pa_data);
                set_req(1'b1, 1'b1, pb_wr, pb_addr, pb_data);
                first = pick(1'b1, 1'b1);
                if (first) begin
                    serve(1'b1, pb_wr, pb_addr, pb_data, 1'b0, 3);
                    serve(1'b0, pa_wr, pa_addr, pa_data, 1'b0, 4);
                end else begin
                    serve(1'b0, pa_wr, pa_addr, pa_data, 1'b0, 3);
                    serve(1'b1, pb_wr, pb_addr, pb_data, 1'b0, 4);
                end
            end
            idle_gap();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
